// File: rtl/sd_pkg.sv
// Shared definitions for the SD card SPI-mode initialisation controller.
// Holds the fixed 48-bit command frames (CRC included), the controller
// state and sub-phase enums, the err_code values and frame helpers.
package sd_pkg;

    localparam logic [47:0] CMD0   = 48'h400000000095;
    localparam logic [47:0] CMD8   = 48'h48000001AA87;
    localparam logic [47:0] CMD55  = 48'h770000000065;
    localparam logic [47:0] ACMD41 = 48'h694000000077;
    localparam logic [47:0] CMD58  = 48'h7A00000000FD;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_DUMMY  = 4'd1,
        ST_CMD0   = 4'd2,
        ST_CMD8   = 4'd3,
        ST_CMD55  = 4'd4,
        ST_ACMD41 = 4'd5,
        ST_CMD58  = 4'd6,
        ST_DONE   = 4'd7,
        ST_FAIL   = 4'd8
    } sd_state_t;

    // Progress inside one command: frame out, R1 poll, trailing bytes, 8-clock gap.
    typedef enum logic [1:0] {
        PH_SEND  = 2'd0,
        PH_POLL  = 2'd1,
        PH_TRAIL = 2'd2,
        PH_GAP   = 2'd3
    } sd_phase_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CMD0    = 3'd1;
    localparam logic [2:0] ERR_CMD8    = 3'd2;
    localparam logic [2:0] ERR_ACMD41  = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_CMD58   = 3'd5;

    function automatic logic [47:0] cmd_frame(input sd_state_t st);
        case (st)
            ST_CMD0:   return CMD0;
            ST_CMD8:   return CMD8;
            ST_CMD55:  return CMD55;
            ST_ACMD41: return ACMD41;
            ST_CMD58:  return CMD58;
            default:   return {48{1'b1}};
        endcase
    endfunction

    // Byte idx (0 = first on the wire) of the frame for command state st.
    function automatic logic [7:0] frame_byte(input sd_state_t st, input logic [2:0] idx);
        logic [47:0] f;
        f = cmd_frame(st);
        case (idx)
            3'd0:    return f[47:40];
            3'd1:    return f[39:32];
            3'd2:    return f[31:24];
            3'd3:    return f[23:16];
            3'd4:    return f[15:8];
            3'd5:    return f[7:0];
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_cmd_state(input sd_state_t st);
        case (st)
            ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD58: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte engine with clock divider.
// Ports: clk/rst (sync, active-high); start + tx_byte + bit_len launch a
// transfer of bit_len (1..8) bits, MSB first; done pulses one cycle after
// the last falling sclk edge with rx_byte holding the sampled bits;
// sclk idles low, mosi changes on falling sclk and idles high; miso is
// sampled on rising sclk.
module sd_spi_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic [3:0] bit_len,
    input  logic       miso,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sclk,
    output logic       mosi
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic       active_r;
    logic       sclk_r;
    logic       mosi_r;
    logic       done_r;
    logic [7:0] div_r;
    logic [3:0] bit_r;
    logic [3:0] len_r;
    logic [7:0] tx_r;
    logic [7:0] rx_r;

    // Divider, sclk toggling, shift-out on falling and shift-in on rising edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r <= 1'b0;
            sclk_r   <= 1'b0;
            mosi_r   <= 1'b1;
            done_r   <= 1'b0;
            div_r    <= 8'd0;
            bit_r    <= 4'd0;
            len_r    <= 4'd0;
            tx_r     <= 8'hFF;
            rx_r     <= 8'd0;
        end else begin
            done_r <= 1'b0;
            if (!active_r) begin
                if (start) begin
                    active_r <= 1'b1;
                    mosi_r   <= tx_byte[7];
                    tx_r     <= {tx_byte[6:0], 1'b1};
                    div_r    <= 8'd0;
                    bit_r    <= 4'd0;
                    len_r    <= bit_len;
                end
            end else if (div_r == DIV_LAST) begin
                div_r  <= 8'd0;
                sclk_r <= ~sclk_r;
                if (!sclk_r) begin
                    rx_r <= {rx_r[6:0], miso};
                end else if (bit_r == 4'(len_r - 4'd1)) begin
                    active_r <= 1'b0;
                    done_r   <= 1'b1;
                    mosi_r   <= 1'b1;
                end else begin
                    bit_r  <= bit_r + 4'd1;
                    mosi_r <= tx_r[7];
                    tx_r   <= {tx_r[6:0], 1'b1};
                end
            end else begin
                div_r <= div_r + 8'd1;
            end
        end
    end

    assign done    = done_r;
    assign rx_byte = rx_r;
    assign sclk    = sclk_r;
    assign mosi    = mosi_r;

endmodule

// File: rtl/sd_spi_init_ctrl.sv
// SD card SPI-mode initialisation sequencer:
// dummy clocks, CMD0, CMD8, CMD55/ACMD41 loop, optional CMD58, DONE/FAIL.
// Ports: sd_ck clock, rst sync active-high reset, sd_init start request,
// sd_miso/sd_sclk/sd_mosi/sd_csn SPI pins, busy, sticky init_ok/init_fail,
// err_code failure cause, card_sdhc OCR CCS bit.
// Build option: define SD_CMD58_EN to read the OCR with CMD58 and latch
// card_sdhc; otherwise ACMD41 success goes straight to DONE, card_sdhc=0.
module sd_spi_init_ctrl
    import sd_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int DUMMY_CLKS   = 80,
    parameter int RESP_TIMEOUT = 8,
    parameter int ACMD41_RETRY = 1000
) (
    input  logic       sd_ck,
    input  logic       rst,
    input  logic       sd_init,
    input  logic       sd_miso,
    output logic       sd_sclk,
    output logic       sd_mosi,
    output logic       sd_csn,
    output logic       busy,
    output logic       init_ok,
    output logic       init_fail,
    output logic [2:0] err_code,
    output logic       card_sdhc
);

`ifdef SD_CMD58_EN
    localparam sd_state_t AFTER_ACMD41 = ST_CMD58;
`else
    localparam sd_state_t AFTER_ACMD41 = ST_DONE;
`endif
    localparam logic [15:0] TIMEOUT_LAST = 16'(RESP_TIMEOUT - 1);

    sd_state_t   state_r, state_nx, nxt_r, nxt_nx;
    sd_phase_t   phase_r, phase_nx;
    logic [15:0] cnt_r, cnt_nx, dummy_r, dummy_nx, attempt_r, attempt_nx;
    logic [3:0]  volt_r, volt_nx;
    logic        xfer_r, xfer_nx, csn_r, csn_nx, busy_r, busy_nx;
    logic        ok_r, ok_nx, fail_r, fail_nx;
    logic [2:0]  err_r, err_nx;
`ifdef SD_CMD58_EN
    logic        sdhc_r, sdhc_nx;
`endif
    logic        start_s, done_s, sclk_s, mosi_s;
    logic [7:0]  tx_s, rx_s;
    logic [3:0]  len_s;

    sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk     (sd_ck),
        .rst     (rst),
        .start   (start_s),
        .tx_byte (tx_s),
        .bit_len (len_s),
        .miso    (sd_miso),
        .done    (done_s),
        .rx_byte (rx_s),
        .sclk    (sclk_s),
        .mosi    (mosi_s)
    );

    // State and datapath registers.
    always_ff @(posedge sd_ck) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            nxt_r     <= ST_IDLE;
            phase_r   <= PH_SEND;
            cnt_r     <= 16'd0;
            dummy_r   <= 16'd0;
            attempt_r <= 16'd0;
            volt_r    <= 4'd0;
            xfer_r    <= 1'b0;
            csn_r     <= 1'b1;
            busy_r    <= 1'b0;
            ok_r      <= 1'b0;
            fail_r    <= 1'b0;
            err_r     <= ERR_NONE;
`ifdef SD_CMD58_EN
            sdhc_r    <= 1'b0;
`endif
        end else begin
            state_r   <= state_nx;
            nxt_r     <= nxt_nx;
            phase_r   <= phase_nx;
            cnt_r     <= cnt_nx;
            dummy_r   <= dummy_nx;
            attempt_r <= attempt_nx;
            volt_r    <= volt_nx;
            xfer_r    <= xfer_nx;
            csn_r     <= csn_nx;
            busy_r    <= busy_nx;
            ok_r      <= ok_nx;
            fail_r    <= fail_nx;
            err_r     <= err_nx;
`ifdef SD_CMD58_EN
            sdhc_r    <= sdhc_nx;
`endif
        end
    end

    // Next-state logic: one byte in flight at a time, decisions taken on its completion.
    always_comb begin
        state_nx   = state_r;
        nxt_nx     = nxt_r;
        phase_nx   = phase_r;
        cnt_nx     = cnt_r;
        dummy_nx   = dummy_r;
        attempt_nx = attempt_r;
        volt_nx    = volt_r;
        xfer_nx    = xfer_r;
        err_nx     = err_r;
`ifdef SD_CMD58_EN
        sdhc_nx    = sdhc_r;
`endif
        start_s    = 1'b0;
        tx_s       = 8'hFF;
        // The last dummy "byte" may be short so the dummy clock count is exact.
        if (state_r == ST_DUMMY && dummy_r < 16'd8) begin
            len_s = dummy_r[3:0];
        end else begin
            len_s = 4'd8;
        end

        case (state_r)
            ST_IDLE: begin
                if (sd_init && !ok_r && !fail_r) begin
                    state_nx = ST_DUMMY;
                    dummy_nx = 16'(DUMMY_CLKS);
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_DONE, ST_FAIL: begin
                state_nx = state_r;
            end
            ST_DUMMY, ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD58: begin
                if (!xfer_r) begin
                    start_s = 1'b1;
                    xfer_nx = 1'b1;
                    if (phase_r == PH_SEND && state_r != ST_DUMMY) begin
                        tx_s = frame_byte(state_r, cnt_r[2:0]);
                    end else begin
                        tx_s = 8'hFF;
                    end
                end else if (done_s) begin
                    xfer_nx = 1'b0;
                    if (state_r == ST_DUMMY) begin
                        dummy_nx = dummy_r - {12'd0, len_s};
                        if (dummy_r <= {12'd0, len_s}) begin
                            state_nx = ST_CMD0;
                            phase_nx = PH_SEND;
                            cnt_nx   = 16'd0;
                        end else begin
                            state_nx = ST_DUMMY;
                        end
                    end else begin
                        case (phase_r)
                            PH_SEND: begin
                                if (cnt_r == 16'd5) begin
                                    phase_nx = PH_POLL;
                                    cnt_nx   = 16'd0;
                                end else begin
                                    cnt_nx = cnt_r + 16'd1;
                                end
                            end
                            PH_POLL: begin
                                if (!rx_s[7]) begin
                                    case (state_r)
                                        ST_CMD0: begin
                                            if (rx_s == 8'h01) begin
                                                phase_nx = PH_GAP;
                                                nxt_nx   = ST_CMD8;
                                            end else begin
                                                state_nx = ST_FAIL;
                                                err_nx   = ERR_CMD0;
                                            end
                                        end
                                        ST_CMD8: begin
                                            if (rx_s == 8'h01) begin
                                                phase_nx = PH_TRAIL;
                                                cnt_nx   = 16'd0;
                                            end else begin
                                                state_nx = ST_FAIL;
                                                err_nx   = ERR_CMD8;
                                            end
                                        end
                                        ST_CMD55: begin
                                            if (rx_s == 8'h01) begin
                                                phase_nx = PH_GAP;
                                                nxt_nx   = ST_ACMD41;
                                            end else begin
                                                state_nx = ST_FAIL;
                                                err_nx   = ERR_ACMD41;
                                            end
                                        end
                                        ST_ACMD41: begin
                                            if (rx_s == 8'h00) begin
                                                phase_nx = PH_GAP;
                                                nxt_nx   = AFTER_ACMD41;
                                            end else if (rx_s == 8'h01 && attempt_r < 16'(ACMD41_RETRY)) begin
                                                phase_nx = PH_GAP;
                                                nxt_nx   = ST_CMD55;
                                            end else begin
                                                state_nx = ST_FAIL;
                                                err_nx   = ERR_ACMD41;
                                            end
                                        end
                                        ST_CMD58: begin
                                            if (rx_s == 8'h00) begin
                                                phase_nx = PH_TRAIL;
                                                cnt_nx   = 16'd0;
                                            end else begin
                                                state_nx = ST_FAIL;
                                                err_nx   = ERR_CMD58;
                                            end
                                        end
                                        default: begin
                                            state_nx = ST_FAIL;
                                            err_nx   = ERR_TIMEOUT;
                                        end
                                    endcase
                                end else if (cnt_r == TIMEOUT_LAST) begin
                                    state_nx = ST_FAIL;
                                    err_nx   = ERR_TIMEOUT;
                                end else begin
                                    cnt_nx = cnt_r + 16'd1;
                                end
                            end
                            PH_TRAIL: begin
                                // CMD8 echo: byte 2 low nibble = voltage, byte 3 = check pattern.
                                if (cnt_r == 16'd2) begin
                                    volt_nx = rx_s[3:0];
                                end else begin
                                    volt_nx = volt_r;
                                end
`ifdef SD_CMD58_EN
                                // OCR bit 30 (CCS) is bit 6 of the first OCR byte.
                                if (state_r == ST_CMD58 && cnt_r == 16'd0) begin
                                    sdhc_nx = rx_s[6];
                                end else begin
                                    sdhc_nx = sdhc_r;
                                end
`endif
                                if (cnt_r == 16'd3) begin
                                    if (state_r == ST_CMD58) begin
                                        phase_nx = PH_GAP;
                                        nxt_nx   = ST_DONE;
                                    end else if (volt_r == 4'h1 && rx_s == 8'hAA) begin
                                        phase_nx = PH_GAP;
                                        nxt_nx   = ST_CMD55;
                                    end else begin
                                        state_nx = ST_FAIL;
                                        err_nx   = ERR_CMD8;
                                    end
                                end else begin
                                    cnt_nx = cnt_r + 16'd1;
                                end
                            end
                            PH_GAP: begin
                                state_nx = nxt_r;
                                phase_nx = PH_SEND;
                                cnt_nx   = 16'd0;
                                // Attempt counter saturates rather than wrapping.
                                if (nxt_r == ST_CMD55 && attempt_r != 16'hFFFF) begin
                                    attempt_nx = attempt_r + 16'd1;
                                end else begin
                                    attempt_nx = attempt_r;
                                end
                            end
                            default: begin
                                state_nx = ST_FAIL;
                                err_nx   = ERR_TIMEOUT;
                            end
                        endcase
                    end
                end else begin
                    xfer_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        csn_nx  = !(is_cmd_state(state_nx) && phase_nx != PH_GAP);
        busy_nx = !(state_nx == ST_IDLE || state_nx == ST_DONE || state_nx == ST_FAIL);
        ok_nx   = ok_r || (state_nx == ST_DONE);
        fail_nx = fail_r || (state_nx == ST_FAIL);
    end

    assign sd_sclk   = sclk_s;
    assign sd_mosi   = mosi_s;
    assign sd_csn    = csn_r;
    assign busy      = busy_r;
    assign init_ok   = ok_r;
    assign init_fail = fail_r;
    assign err_code  = err_r;
`ifdef SD_CMD58_EN
    assign card_sdhc = sdhc_r;
`else
    assign card_sdhc = 1'b0;
`endif

endmodule

// File: doc/sd_spi_init_ctrl.md
SD_SPI_INIT_CTRL -- requirements
Module: sd_spi_init_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4: sd_sclk half-period in sd_ck cycles, legal range 2..255.
REQ-002 SHALL provide parameter DUMMY_CLKS, default 80: sd_sclk cycles issued with sd_csn=1 before CMD0.
REQ-003 SHALL provide parameter RESP_TIMEOUT, default 8: response bytes polled before a timeout is declared.
REQ-004 SHALL provide parameter ACMD41_RETRY, default 1000: maximum CMD55+ACMD41 attempts.
REQ-005 SHALL provide port sd_ck, input, 1 bit: the single clock; all logic clocks on its rising edge.
REQ-006 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL provide port sd_init, input, 1 bit: start request, sampled only in IDLE.
REQ-008 SHALL provide port sd_miso, input, 1 bit: card data out.
REQ-009 SHALL provide port sd_sclk, output, 1 bit: SPI clock, mode 0.
REQ-010 SHALL provide port sd_mosi, output, 1 bit: card data in.
REQ-011 SHALL provide port sd_csn, output, 1 bit: card select, active-low.
REQ-012 SHALL provide port busy, output, 1 bit: high while the sequence runs.
REQ-013 SHALL provide port init_ok, output, 1 bit: sticky success flag.
REQ-014 SHALL provide port init_fail, output, 1 bit: sticky failure flag.
REQ-015 SHALL provide port err_code, output, 3 bits: failure cause.
REQ-016 SHALL provide port card_sdhc, output, 1 bit: OCR CCS bit.

Function
REQ-017 SHALL idle sd_sclk low, change sd_mosi only on falling sd_sclk, sample sd_miso on rising sd_sclk, and transmit MSB first.
REQ-018 SHALL implement states IDLE, DUMMY, CMD0, CMD8, CMD55, ACMD41, CMD58, DONE, FAIL.
REQ-019 SHALL transition IDLE->DUMMY only when sd_init=1 and init_ok=0 and init_fail=0.
REQ-020 SHALL hold sd_csn=1 and sd_mosi=1 in DUMMY for exactly DUMMY_CLKS sd_sclk cycles, then enter CMD0.
REQ-021 SHALL, per command, drive sd_csn=0, shift out 48 bits, then clock 0xFF bytes until a byte with MSB=0 (R1) arrives; no R1 within RESP_TIMEOUT bytes SHALL give FAIL with err_code=4.
REQ-022 SHALL, after each command, raise sd_csn and issue 8 further sd_sclk cycles with sd_mosi=1 before the next command.
REQ-023 SHALL accept only R1=0x01 after CMD0; any other R1 SHALL give FAIL with err_code=1.
REQ-024 SHALL read 4 trailing bytes after CMD8; R1=0x01 with voltage nibble 0x1 and pattern 0xAA SHALL advance to CMD55; any other value SHALL give FAIL with err_code=2.
REQ-025 SHALL require R1=0x01 after CMD55 (otherwise err_code=3), and after ACMD41 SHALL advance on R1=0x00, retry CMD55 on R1=0x01, and fail otherwise.
REQ-026 SHALL count attempts from 1 and, if attempt ACMD41_RETRY completes with R1=0x01, give FAIL with err_code=3.
REQ-027 SHALL, in DONE, set init_ok=1 and busy=0 and hold sd_csn=1; in FAIL, set init_fail=1 and busy=0 and hold sd_csn=1; both states SHALL be held until reset.
REQ-028 SHALL use err_code 0 for none; a 16-bit attempt counter SHALL saturate and not wrap.

Reset
REQ-029 SHALL, one cycle after rst=1, force state=IDLE, sd_sclk=0, sd_mosi=1, sd_csn=1, busy=0, init_ok=0, init_fail=0, err_code=0, card_sdhc=0, and all counters to 0, mid-transfer included.

Configuration
REQ-030 SHALL, with SD_CMD58_EN defined, follow ACMD41 success with CMD58 (R1 must be 0x00, else err_code=5), read 4 OCR bytes, and latch card_sdhc=OCR bit 30 before DONE.
REQ-031 SHALL, without SD_CMD58_EN, go from ACMD41 success straight to DONE with card_sdhc tied to 0.

Structure
REQ-032 SHALL place the following in shared package sd_pkg: CMD0=48'h400000000095, CMD8=48'h48000001AA87, CMD55=48'h770000000065, ACMD41=48'h694000000077, CMD58=48'h7A00000000FD, the state enum, and the err_code constants.
REQ-033 SHALL implement the byte-level SPI shift and clock divider in sub-module sd_spi_byte (start/done handshake, 8-bit tx/rx).

Verification
REQ-034 SHALL verify the happy path: card model returns 0x01, 0x01+000001AA, 0x01, 0x00, 0x00+C0FF8000 -> init_ok=1, card_sdhc=1, err_code=0, exactly 80 dummy clocks.
REQ-035 SHALL verify CMD0 timeout: miso stuck at 1 -> init_fail=1, err_code=4 after 8 polled bytes.
REQ-036 SHALL verify a CMD8 pattern echo of 0x55 -> init_fail=1, err_code=2.
REQ-037 SHALL verify ACMD41_RETRY=3 with ACMD41 always 0x01 -> exactly 3 ACMD41 frames, then err_code=3.
REQ-038 SHALL verify rst asserted mid-CMD8 -> next cycle sd_csn=1 and busy=0; re-issuing sd_init restarts from DUMMY.
REQ-039 SHALL verify the build without SD_CMD58_EN: no 0x7A frame, card_sdhc=0, init_ok=1.
